// File: rtl/icache_pkg.sv
// Shared types, width helpers and constants for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        FILLED = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // Word-offset bits within a line.
    function automatic int unsigned offset_w(input int unsigned words);
        return $clog2(words);
    endfunction

    // Line-index bits.
    function automatic int unsigned index_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Tag bits: everything above index, offset and the byte lane.
    function automatic int unsigned tag_w(input int unsigned lines, input int unsigned words);
        return 32 - $clog2(lines) - $clog2(words) - 2;
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data store: one synchronous write port, one combinational read port.
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4,
    localparam int unsigned INDEX_W  = index_w(LINES),
    localparam int unsigned OFFSET_W = offset_w(WORDS)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [INDEX_W-1:0]  widx,
    input  logic [OFFSET_W-1:0] woff,
    input  logic [31:0]         wdata,
    input  logic [INDEX_W-1:0]  ridx,
    input  logic [OFFSET_W-1:0] roff,
    output logic [31:0]         rdata
);

    logic [31:0] mem [LINES][WORDS];

    // Refill writes; contents are never reset, validity is tracked in the tag store.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx][woff] <= wdata;
        end
    end

    // Lookup read straight from the current PC.
    always_comb begin
        rdata = mem[ridx][roff];
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with word-serial line refill.
module icache_dm
    import icache_pkg::*;
#(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic [31:0] i_addr_pc,
    input  logic        i_con_flush,
    output logic [31:0] o_data_instr,
    output logic        o_con_stall,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam int unsigned OFFSET_W = offset_w(WORDS);
    localparam int unsigned INDEX_W  = index_w(LINES);
    localparam int unsigned TAG_W    = tag_w(LINES, WORDS);

    state_t              state_q;
    state_t              state_d;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q [LINES];
    logic [INDEX_W-1:0]  line_idx_q;
    logic [TAG_W-1:0]    line_tag_q;
    logic [OFFSET_W-1:0] cnt_q;
    logic                flush_pend_q;
    logic                mem_req_q;
    logic [31:0]         mem_addr_q;

    logic [OFFSET_W-1:0] pc_off;
    logic [INDEX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]    pc_tag;
    logic                unused_pc_bits;
    logic                hit;
    logic                miss;
    logic                word_ack;
    logic                last_ack;
    logic                ram_we;
    logic [31:0]         ram_rdata;

    // PC field split and lookup/handshake qualifiers.
    always_comb begin
        pc_off         = i_addr_pc[OFFSET_W+1:2];
        pc_idx         = i_addr_pc[OFFSET_W+2 +: INDEX_W];
        pc_tag         = i_addr_pc[31 -: TAG_W];
        unused_pc_bits = ^i_addr_pc[1:0];
        hit            = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
        miss           = (state_q == IDLE) && !hit;
        word_ack       = (state_q == REFILL) && mem_req_q && i_mem_ack;
        last_ack       = word_ack && (cnt_q == OFFSET_W'(WORDS - 1));
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss) state_d = REFILL;
            REFILL:  if (last_ack) state_d = FILLED;
            FILLED:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: hit data or NOP with stall, and refill write strobe.
    always_comb begin
        o_con_stall  = 1'b1;
        o_data_instr = NOP;
        ram_we       = word_ack;
        if (hit) begin
            o_con_stall  = 1'b0;
            o_data_instr = ram_rdata;
        end
    end

    // Refill request, address walk and word counter.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            cnt_q      <= '0;
            line_idx_q <= '0;
            line_tag_q <= '0;
        end else if (miss) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= {pc_tag, pc_idx, (OFFSET_W + 2)'(0)};
            cnt_q      <= '0;
            line_idx_q <= pc_idx;
            line_tag_q <= pc_tag;
        end else if (word_ack) begin
            cnt_q      <= cnt_q + OFFSET_W'(1);
            mem_addr_q <= mem_addr_q + 32'd4;
            if (last_ack) begin
                mem_req_q <= 1'b0;
            end
        end
    end

    // Valid bits and the flush-during-refill marker.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            if (i_con_flush) begin
                valid_q <= '0;
            end else if (last_ack && !flush_pend_q) begin
                valid_q[line_idx_q] <= 1'b1;
            end

            if (state_q == FILLED) begin
                flush_pend_q <= 1'b0;
            end else if (i_con_flush && state_q == REFILL) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

    // Tag write on completion of a line; tags need no reset.
    always_ff @(posedge i_clk) begin
        if (last_ack) begin
            tag_q[line_idx_q] <= line_tag_q;
        end
    end

    assign o_mem_req  = mem_req_q;
    assign o_mem_addr = mem_addr_q;

    icache_data_ram #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_data_ram (
        .clk   (i_clk),
        .we    (ram_we),
        .widx  (line_idx_q),
        .woff  (cnt_q),
        .wdata (i_mem_rdata),
        .ridx  (pc_idx),
        .roff  (pc_off),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm with a zero/multi-wait word memory model.
module tb_icache_dm;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        i_clk;
    logic        i_nrst;
    logic [31:0] i_addr_pc;
    logic        i_con_flush;
    logic [31:0] o_data_instr;
    logic        o_con_stall;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    icache_dm #(.LINES(16), .WORDS(4)) dut (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_addr_pc    (i_addr_pc),
        .i_con_flush  (i_con_flush),
        .o_data_instr (o_data_instr),
        .o_con_stall  (o_con_stall),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Hold PC until a hit; memory acks every waitn-th request cycle. Entered and left at posedge+1.
    task automatic fetch(input logic [31:0] pc, input int waitn, input int flush_at,
                         output int stalls, output int nacks, output int addr_err,
                         output logic [31:0] data, output bit done);
        int w;
        logic [31:0] base;
        base     = pc & 32'hFFFF_FFF0;
        stalls   = 0;
        nacks    = 0;
        addr_err = 0;
        data     = 32'h0;
        done     = 1'b0;
        w        = 0;
        i_addr_pc = pc;
        for (int c = 0; c < 300 && !done; c++) begin
            i_mem_ack   = 1'b0;
            i_con_flush = 1'b0;
            if (o_mem_req) begin
                if (o_mem_addr !== base + 32'(4 * (nacks % 4))) addr_err++;
                if (w == waitn - 1) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = o_mem_addr ^ K;
                    nacks++;
                    w = 0;
                    if (nacks == flush_at) i_con_flush = 1'b1;
                end else begin
                    w++;
                end
            end
            #1;
            if (!o_con_stall) begin
                data = o_data_instr;
                done = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge i_clk);
            #1;
        end
        i_mem_ack   = 1'b0;
        i_con_flush = 1'b0;
    endtask

    task automatic do_fetch(input string name, input logic [31:0] pc, input int waitn,
                            input int flush_at, input int exp_stalls, input int exp_nacks);
        int stalls, nacks, addr_err;
        logic [31:0] data;
        bit done;
        fetch(pc, waitn, flush_at, stalls, nacks, addr_err, data, done);
        check({name, "_done"},   32'(done), 32'd1);
        check({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        check({name, "_reqs"},   32'(nacks), 32'(exp_nacks));
        check({name, "_addr"},   32'(addr_err), 32'd0);
        check({name, "_data"},   data, pc ^ K);
    endtask

    initial begin
        i_nrst      = 1'b0;
        i_addr_pc   = 32'h0000_0100;
        i_con_flush = 1'b0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_stall", 32'(o_con_stall), 32'd1);
        check("rst_instr", o_data_instr, 32'h0);
        check("rst_req",   32'(o_mem_req), 32'd0);
        check("rst_addr",  o_mem_addr, 32'h0);
        i_nrst = 1'b1;

        // Cold fetch then sequential hits in the same line.
        do_fetch("cold", 32'h0000_0100, 1, 0, 6, 4);
        do_fetch("seq4", 32'h0000_0104, 1, 0, 0, 0);
        do_fetch("seq8", 32'h0000_0108, 1, 0, 0, 0);
        do_fetch("seqc", 32'h0000_010C, 1, 0, 0, 0);

        // Same index, different tag evicts and reloads.
        do_fetch("evict1", 32'h0000_1100, 1, 0, 6, 4);
        do_fetch("evict2", 32'h0000_0100, 1, 0, 6, 4);
        do_fetch("evict_hit", 32'h0000_0108, 1, 0, 0, 0);

        // Memory acks only every third cycle.
        do_fetch("wait3", 32'h0000_2204, 3, 0, 14, 4);

        // Flush on the second ack: line not validated, second refill follows.
        do_fetch("flush_rf", 32'h0000_0440, 1, 2, 12, 8);
        do_fetch("flush_hit", 32'h0000_044C, 1, 0, 0, 0);

        // Flush while idle invalidates the resident line.
        i_con_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_con_flush = 1'b0;
        do_fetch("flush_idle", 32'h0000_044C, 1, 0, 6, 4);

        // Reset after two acks abandons the refill.
        i_addr_pc = 32'h0000_0300;
        @(posedge i_clk);
        #1;
        check("mid_req",   32'(o_mem_req), 32'd1);
        check("mid_addr0", o_mem_addr, 32'h0000_0300);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h0000_0300 ^ K;
        @(posedge i_clk);
        #1;
        i_mem_rdata = 32'h0000_0304 ^ K;
        @(posedge i_clk);
        #1;
        i_mem_ack = 1'b0;
        check("mid_addr2", o_mem_addr, 32'h0000_0308);
        i_nrst = 1'b0;
        #1;
        check("mid_rst_req",   32'(o_mem_req), 32'd0);
        check("mid_rst_addr",  o_mem_addr, 32'h0);
        check("mid_rst_stall", 32'(o_con_stall), 32'd1);
        @(posedge i_clk);
        #1;
        i_nrst = 1'b1;
        do_fetch("post_rst", 32'h0000_0300, 1, 0, 6, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
